// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: owns the h/v counters and registers sync, blank,
// pixel request (with lead), row/col and line/frame pulses. Optional colour-bar
// pattern outputs are enabled by defining VGA_TIMING_PATTERN_EN.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int REQ_LEAD = 2,
  parameter int CNT_W    = 13
) (
  input  logic             VGA_CLK,
  input  logic             RESET_N,
  input  logic             i_enable,
  output logic             VGA_HS,
  output logic             VGA_VS,
  output logic             VGA_BLANK_N,
  output logic             o_request,
  output logic [CNT_W-1:0] o_col,
  output logic [CNT_W-1:0] o_row,
  output logic             o_line_start,
  output logic             o_frame_start
`ifdef VGA_TIMING_PATTERN_EN
  ,
  output logic [7:0]       o_pat_R,
  output logic [7:0]       o_pat_G,
  output logic [7:0]       o_pat_B
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_LAST_C = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST_C = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HS_BEG_C = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END_C = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG_C = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END_C = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [CNT_W-1:0] ONE_C    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W:0]   H_TOT_P  = (CNT_W+1)'(H_TOTAL);
  localparam logic [CNT_W:0]   LEAD_P   = (CNT_W+1)'(REQ_LEAD);
  localparam logic             HS_ON_C  = 1'(HS_POL);
  localparam logic             VS_ON_C  = 1'(VS_POL);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic [CNT_W-1:0] col_q, row_q;
  logic             hs_q, vs_q, blank_n_q, req_q, line_start_q, frame_start_q;

  logic             active_s, hs_s, vs_s, req_s;
  logic [CNT_W:0]   p_s, px_s;
  logic [CNT_W-1:0] pline_s;

  // Raster counter next state.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (i_enable) begin
      if (h_cnt_q == H_LAST_C) begin
        h_cnt_d = '0;
        if (v_cnt_q == V_LAST_C) begin
          v_cnt_d = '0;
        end else begin
          v_cnt_d = v_cnt_q + ONE_C;
        end
      end else begin
        h_cnt_d = h_cnt_q + ONE_C;
      end
    end else begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
    end
  end

  // Decode of the current counter position.
  always_comb begin
    active_s = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
    hs_s     = ((h_cnt_q >= HS_BEG_C) && (h_cnt_q < HS_END_C)) ? HS_ON_C : ~HS_ON_C;
    vs_s     = ((v_cnt_q >= VS_BEG_C) && (v_cnt_q < VS_END_C)) ? VS_ON_C : ~VS_ON_C;
    // Request looks REQ_LEAD clocks ahead, possibly into the next line or frame.
    p_s      = {1'b0, h_cnt_q} + LEAD_P;
    if (p_s < H_TOT_P) begin
      px_s    = p_s;
      pline_s = v_cnt_q;
    end else begin
      px_s    = p_s - H_TOT_P;
      pline_s = (v_cnt_q == V_LAST_C) ? '0 : (v_cnt_q + ONE_C);
    end
    req_s    = (px_s < {1'b0, H_ACT_C}) && (pline_s < V_ACT_C);
  end

  // Counter state.
  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Registered timing outputs; frozen while disabled, pulses cleared.
  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hs_q          <= ~HS_ON_C;
      vs_q          <= ~VS_ON_C;
      blank_n_q     <= 1'b0;
      req_q         <= 1'b0;
      col_q         <= '0;
      row_q         <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (i_enable) begin
      hs_q          <= hs_s;
      vs_q          <= vs_s;
      blank_n_q     <= active_s;
      req_q         <= req_s;
      if (active_s) begin
        col_q <= h_cnt_q;
        row_q <= v_cnt_q;
      end
      line_start_q  <= (h_cnt_q == '0);
      frame_start_q <= (h_cnt_q == '0) && (v_cnt_q == '0);
    end else begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end
  end

  assign VGA_HS        = hs_q;
  assign VGA_VS        = vs_q;
  assign VGA_BLANK_N   = blank_n_q;
  assign o_request     = req_q;
  assign o_col         = col_q;
  assign o_row         = row_q;
  assign o_line_start  = line_start_q;
  assign o_frame_start = frame_start_q;

`ifdef VGA_TIMING_PATTERN_EN
  localparam logic [CNT_W+2:0] BAR_DIV_C = (CNT_W+3)'(H_ACTIVE);

  logic [2:0] bar_s;
  logic [2:0] rgb_s;
  logic [7:0] pat_r_q, pat_g_q, pat_b_q;

  // Eight vertical colour bars across the active width.
  always_comb begin
    bar_s = 3'(({h_cnt_q, 3'b000}) / BAR_DIV_C);
    case (bar_s)
      3'd0:    rgb_s = 3'b111;
      3'd1:    rgb_s = 3'b110;
      3'd2:    rgb_s = 3'b011;
      3'd3:    rgb_s = 3'b010;
      3'd4:    rgb_s = 3'b101;
      3'd5:    rgb_s = 3'b100;
      3'd6:    rgb_s = 3'b001;
      default: rgb_s = 3'b000;
    endcase
  end

  // Pattern registers track VGA_BLANK_N timing.
  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pat_r_q <= 8'h00;
      pat_g_q <= 8'h00;
      pat_b_q <= 8'h00;
    end else if (i_enable) begin
      pat_r_q <= (active_s && rgb_s[2]) ? 8'hFF : 8'h00;
      pat_g_q <= (active_s && rgb_s[1]) ? 8'hFF : 8'h00;
      pat_b_q <= (active_s && rgb_s[0]) ? 8'hFF : 8'h00;
    end
  end

  assign o_pat_R = pat_r_q;
  assign o_pat_G = pat_g_q;
  assign o_pat_B = pat_b_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default horizontal timing, shortened
// vertical geometry (20 active lines, 29 total) so a full frame stays short.
module tb_vga_timing_gen;

  localparam int HT    = 800;
  localparam int VT    = 29;
  localparam int FRAME = HT * VT;

  logic        VGA_CLK = 1'b0;
  logic        RESET_N;
  logic        i_enable;
  logic        VGA_HS, VGA_VS, VGA_BLANK_N, o_request, o_line_start, o_frame_start;
  logic [12:0] o_col, o_row;
`ifdef VGA_TIMING_PATTERN_EN
  logic [7:0]  o_pat_R, o_pat_G, o_pat_B;
`endif

  int check_cnt = 0;
  int err_cnt   = 0;

  int hs_low_l0, first_hs, vs_low, first_vs, req_cnt, blank_cnt;
  int blank_low_l0, ls_cnt, fs_cnt, lead_err, changes, k;
  logic [1:0]  req_hist;
  logic [31:0] snap;
  logic [31:0] out_vec;

  assign out_vec = {VGA_HS, VGA_VS, VGA_BLANK_N, o_request, o_col, o_row,
                    o_line_start, o_frame_start};

  vga_timing_gen #(
    .V_ACTIVE(20), .V_FRONT(3), .V_SYNC(2), .V_BACK(4)
  ) dut (
    .VGA_CLK      (VGA_CLK),
    .RESET_N      (RESET_N),
    .i_enable     (i_enable),
    .VGA_HS       (VGA_HS),
    .VGA_VS       (VGA_VS),
    .VGA_BLANK_N  (VGA_BLANK_N),
    .o_request    (o_request),
    .o_col        (o_col),
    .o_row        (o_row),
    .o_line_start (o_line_start),
    .o_frame_start(o_frame_start)
`ifdef VGA_TIMING_PATTERN_EN
    ,
    .o_pat_R      (o_pat_R),
    .o_pat_G      (o_pat_G),
    .o_pat_B      (o_pat_B)
`endif
  );

  always #5 VGA_CLK = ~VGA_CLK;

  task automatic check_value(input string tag, input int obs, input int exp);
    check_cnt++;
    if (obs != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge VGA_CLK);
    @(negedge VGA_CLK);
  endtask

  task automatic check_pat(input string tag, input int r, input int g, input int b);
`ifdef VGA_TIMING_PATTERN_EN
    check_value({tag, "_r"}, o_pat_R, r);
    check_value({tag, "_g"}, o_pat_G, g);
    check_value({tag, "_b"}, o_pat_B, b);
`endif
  endtask

  task automatic check_reset_vals(input string tag);
    check_value({tag, "_hs"}, VGA_HS, 1);
    check_value({tag, "_vs"}, VGA_VS, 1);
    check_value({tag, "_blank"}, VGA_BLANK_N, 0);
    check_value({tag, "_req"}, o_request, 0);
    check_value({tag, "_col"}, o_col, 0);
    check_value({tag, "_row"}, o_row, 0);
    check_value({tag, "_ls"}, o_line_start, 0);
    check_value({tag, "_fs"}, o_frame_start, 0);
    check_pat(tag, 0, 0, 0);
  endtask

  initial begin
    RESET_N  = 1'b0;
    i_enable = 1'b1;
    repeat (3) @(negedge VGA_CLK);
    check_reset_vals("rst");
    RESET_N = 1'b1;

    hs_low_l0 = 0; first_hs = -1; vs_low = 0; first_vs = -1;
    req_cnt = 0; blank_cnt = 0; blank_low_l0 = 0; ls_cnt = 0; fs_cnt = 0;
    lead_err = 0; req_hist = 2'b00;

    for (int n = 0; n < FRAME; n++) begin
      tick();
      if (n == 0) begin
        check_value("first_blank", VGA_BLANK_N, 1);
        check_value("first_fs", o_frame_start, 1);
        check_value("first_ls", o_line_start, 1);
        check_value("first_col", o_col, 0);
        check_value("first_row", o_row, 0);
        check_value("first_req", o_request, 1);
        check_value("first_hs", VGA_HS, 1);
        check_pat("pat_c0", 255, 255, 255);
      end
      if (n == 80)  check_pat("pat_c80", 255, 255, 0);
      if (n == 639) begin
        check_value("col639", o_col, 639);
        check_value("blank639", VGA_BLANK_N, 1);
        check_pat("pat_c639", 0, 0, 0);
      end
      if (n == 640) check_pat("pat_blank", 0, 0, 0);
      if (n == 799) begin
        check_value("col_hold", o_col, 639);
        check_value("blank799", VGA_BLANK_N, 0);
      end
      if (n == 19*HT + 5) begin
        check_value("row19", o_row, 19);
        check_value("row19_col", o_col, 5);
      end
      if (n == 20*HT) begin
        check_value("vblank", VGA_BLANK_N, 0);
        check_value("vblank_row", o_row, 19);
        check_value("vblank_col", o_col, 639);
      end
      if (n == FRAME-3) check_value("req_h797", o_request, 0);
      if (n == FRAME-2) check_value("req_h798", o_request, 1);

      if (!VGA_HS) begin
        if (n < HT) hs_low_l0++;
        if (first_hs < 0) first_hs = n;
      end
      if (!VGA_VS) begin
        vs_low++;
        if (first_vs < 0) first_vs = n;
      end
      req_cnt   += int'(o_request);
      blank_cnt += int'(VGA_BLANK_N);
      if (n < HT && !VGA_BLANK_N) blank_low_l0++;
      ls_cnt += int'(o_line_start);
      fs_cnt += int'(o_frame_start);
      if (n >= 2 && VGA_BLANK_N != req_hist[1]) lead_err++;
      req_hist = {req_hist[0], o_request};
    end

    check_value("hs_low_line", hs_low_l0, 96);
    check_value("hs_first", first_hs, 656);
    check_value("vs_low_clks", vs_low, 1600);
    check_value("vs_first", first_vs, 23*HT);
    check_value("req_per_frame", req_cnt, 12800);
    check_value("blank_per_frame", blank_cnt, 12800);
    check_value("hblank_len", blank_low_l0, 160);
    check_value("line_starts", ls_cnt, 29);
    check_value("frame_starts", fs_cnt, 1);
    check_value("req_lead_err", lead_err, 0);

    tick();
    check_value("frame2_fs", o_frame_start, 1);
    check_value("frame2_col", o_col, 0);
    check_value("frame2_row", o_row, 0);

    // Freeze mid-line at column 300.
    repeat (HT + 300) tick();
    check_value("pre_freeze_col", o_col, 300);
    check_value("pre_freeze_row", o_row, 1);
    i_enable = 1'b0;
    snap = out_vec;
    changes = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (out_vec != snap) changes++;
    end
    check_value("freeze_changes", changes, 0);
    check_value("freeze_col", o_col, 300);
    i_enable = 1'b1;
    tick();
    check_value("resume_col", o_col, 301);
    k = 0;
    while (!o_line_start && k < 1000) begin
      tick();
      k++;
    end
    check_value("resume_line_len", k, 499);
    check_value("resume_row", o_row, 2);

    // One disabled clock on a line-start pulse clears the pulse only.
    i_enable = 1'b0;
    tick();
    check_value("dis_ls", o_line_start, 0);
    check_value("dis_col", o_col, 0);
    check_value("dis_row", o_row, 2);
    i_enable = 1'b1;

    // Asynchronous reset mid-frame.
    repeat (8*HT + 100) tick();
    check_value("pre_rst_row", o_row, 10);
    check_value("pre_rst_col", o_col, 100);
    #2;
    RESET_N = 1'b0;
    #1;
    check_reset_vals("async_rst");
    @(negedge VGA_CLK);
    RESET_N = 1'b1;
    tick();
    check_value("post_rst_fs", o_frame_start, 1);
    check_value("post_rst_blank", VGA_BLANK_N, 1);
    check_value("post_rst_col", o_col, 0);
    check_value("post_rst_row", o_row, 0);

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator; replaces ad-hoc combinational sync/blank/request decode of externally supplied x/y counters.
- Owns its own horizontal/vertical counters.
- Emits registered sync, blank, pixel-request (with programmable lead for upstream buffer latency) and active-area row/col.
- Sits between the camera/line-buffer read side and the VGA DAC pins in the top level.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width
H_BACK, 48, horizontal back porch
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BACK, 33, vertical back porch
HS_POL, 0, asserted level of VGA_HS
VS_POL, 0, asserted level of VGA_VS
REQ_LEAD, 2, clocks o_request leads the matching active pixel; legal 0..H_FRONT+H_SYNC+H_BACK
CNT_W, 13, width of counters and row/col

Ports:
VGA_CLK  in  1  pixel clock (25 MHz)
RESET_N  in  1  asynchronous active-low reset
i_enable  in  1  synchronous run enable; low = freeze
VGA_HS  out  1  horizontal sync, polarity per HS_POL
VGA_VS  out  1  vertical sync, polarity per VS_POL
VGA_BLANK_N  out  1  high during active video
o_request  out  1  pixel fetch request, REQ_LEAD clocks ahead of active pixel
o_col  out  CNT_W  active-area column, 0..H_ACTIVE-1
o_row  out  CNT_W  active-area row, 0..V_ACTIVE-1
o_line_start  out  1  one-clock pulse at h_cnt==0 of every line
o_frame_start  out  1  one-clock pulse at h_cnt==0,v_cnt==0

Behaviour:
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL likewise (525).
- Internal h_cnt 0..H_TOTAL-1, v_cnt 0..V_TOTAL-1. Region order per axis: active [0,ACTIVE), front porch, sync, back porch.
- h_cnt increments each enabled clock; at H_TOTAL-1 wraps to 0 and v_cnt increments; v_cnt wraps to 0 after V_TOTAL-1.
- All outputs are registered decodes of (h_cnt,v_cnt): 1-clock latency from counter state to pins.
- HS asserted for h_cnt in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC). VS asserted for v_cnt in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC), for the whole of each such line.
- VGA_BLANK_N = (h_cnt<H_ACTIVE && v_cnt<V_ACTIVE).
- o_col/o_row = h_cnt/v_cnt while active; hold last value during blanking.
- o_request: p = h_cnt+REQ_LEAD.
  - If p<H_TOTAL: x=p, line=v_cnt.
  - Else: x=p-H_TOTAL, line=(v_cnt+1) mod V_TOTAL.
  - Asserted iff x<H_ACTIVE && line<V_ACTIVE.
  - Exactly H_ACTIVE*V_ACTIVE request clocks per frame; each leads its blank-active pixel by exactly REQ_LEAD clocks, including across line and frame wrap.
  - REQ_LEAD=0 makes o_request identical to VGA_BLANK_N.
- i_enable low: counters and all registered outputs hold; pulses forced 0. Resumes from the held position.
- Reset (async, any time incl. mid-frame):
  - h_cnt=v_cnt=0.
  - VGA_HS=~HS_POL, VGA_VS=~VS_POL.
  - VGA_BLANK_N=0, o_request=0, o_col=o_row=0, both pulses 0.
  - First clock after release with enable high registers the decode of (0,0): VGA_BLANK_N=1, o_frame_start=1.
- Counter widths: CNT_W must hold H_TOTAL-1 and V_TOTAL-1; no overflow arithmetic permitted beyond p (CNT_W+1 bits).

Optional Feature:
- Macro VGA_TIMING_PATTERN_EN.
- When defined, adds outputs o_pat_R, o_pat_G, o_pat_B (8 bits each): 8 vertical colour bars, bar index = o_col*8/H_ACTIVE.
  - Bar order: white, yellow, cyan, green, magenta, red, blue, black; channels 8'hFF or 8'h00.
  - Registered alongside VGA_BLANK_N.
  - All 0 when blanked or in reset.
- When undefined: ports absent, no pattern logic.

Test Plan:
- Reset release, enable high, defaults: VGA_HS low for exactly 96 clocks per 800-clock line starting at h_cnt 656; VGA_VS low for 2 lines starting at line 490; frame = 420000 clocks.
- BLANK_N/row/col: first active clock after reset gives col=0,row=0. Clock 639 gives col=639; then BLANK_N=0 for 160 clocks with col held at 639.
- REQ_LEAD=2: o_request rises 2 clocks before BLANK_N at line 0 col 0, including the first request coming from line 524 h_cnt 798. Per-frame request count = 307200.
- i_enable low for 50 clocks mid-line at col 300: all outputs frozen. After re-enable col continues at 301; line length is unchanged in enabled clocks.
- RESET_N pulsed low mid-frame at line 200: outputs immediately take reset values asynchronously. After release, o_frame_start pulses on the first enabled clock.
- VGA_TIMING_PATTERN_EN defined: col 0 gives FF/FF/FF, col 80 gives FF/FF/00, col 639 gives 00/00/00; blanking gives 00/00/00.
